// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Multi-cycle control FSM for a single-issue MIPS-style core. It steps each
// instruction through FETCH, DECODE, EXEC, MEM and WB, classifies the opcode
// as R, I or J type, and drives the PC, IR, register-file, ALU-source and
// memory-handshake controls of the datapath.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   begin or resume execution from IDLE/HALTED
//   opcode[5:0]  in   instr[31:26] from the instruction register
//   alu_zero     in   ALU zero flag (BEQ)
//   imem_ack     in   instruction memory data valid
//   dmem_ack     in   data memory access complete
//   imem_req     out  instruction fetch request
//   dmem_req     out  data memory request
//   dmem_we      out  data memory write (SW)
//   ir_we        out  instruction register load
//   pc_we        out  PC write enable
//   pc_src[1:0]  out  00 = PC+4, 01 = branch target, 10 = jump target
//   reg_we       out  register-file write
//   reg_dst      out  1 = rd (R type), 0 = rt
//   mem_to_reg   out  1 = writeback from memory (LW)
//   alu_src_imm  out  1 = immediate ALU operand
//   itype[1:0]   out  registered class: 00 = R, 01 = I, 10 = J
//   busy         out  FSM in FETCH/DECODE/EXEC/MEM/WB
//   halted       out  FSM in HALTED
//   err          out  sticky bus-timeout error
//   instr_count  out  retired-instruction count, saturating
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic             alu_zero,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_imm,
  output logic [1:0]       itype,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [1:0] TYPE_R = 2'b00;
  localparam logic [1:0] TYPE_I = 2'b01;
  localparam logic [1:0] TYPE_J = 2'b10;

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  // Last wait cycle: if no ack arrives here the bus is declared dead.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED, ERROR
  } state_t;

  state_t            state, state_nx;
  logic [WAIT_W-1:0] wait_cnt;
  logic              retire;

  function automatic logic [1:0] classify(input logic [5:0] op);
    if (op == 6'd0)                     return TYPE_R;
    else if (op >= 6'd1 && op <= 6'd3)  return TYPE_J;
    else                                return TYPE_I;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      itype       <= TYPE_R;
      instr_count <= '0;
      wait_cnt    <= '0;
    end else begin
      state <= state_nx;
      if (state == DECODE)
        itype <= classify(opcode);
      if (retire && instr_count != {CNT_W{1'b1}})
        instr_count <= instr_count + CNT_W'(1);
      // Any state change clears the counter, so FETCH and MEM always start
      // their wait from zero; it only advances while stalled on an ack.
      if (state_nx != state)
        wait_cnt <= '0;
      else if (state == FETCH || state == MEM)
        wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  always_comb begin
    state_nx    = state;
    retire      = 1'b0;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 2'b00;
    reg_we      = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_imm = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;
    err         = 1'b0;

    case (state)
      IDLE: begin
        if (start) state_nx = FETCH;
      end

      FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        // An ack on the final wait cycle still wins over the timeout.
        if (imem_ack) begin
          ir_we    = 1'b1;
          pc_we    = 1'b1;
          state_nx = DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx = ERROR;
        end
      end

      DECODE: begin
        busy     = 1'b1;
        state_nx = EXEC;
      end

      EXEC: begin
        busy        = 1'b1;
        alu_src_imm = (itype == TYPE_I);
        if (itype == TYPE_J) begin
          pc_we    = 1'b1;
          pc_src   = 2'b10;
          state_nx = FETCH;
          retire   = 1'b1;
        end else if (opcode == OP_HALT) begin
          state_nx = HALTED;
          retire   = 1'b1;
        end else if (opcode == OP_BEQ) begin
          pc_src   = 2'b01;
          pc_we    = alu_zero;
          state_nx = FETCH;
          retire   = 1'b1;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          state_nx = MEM;
        end else begin
          state_nx = WB;
        end
      end

      MEM: begin
        busy        = 1'b1;
        dmem_req    = 1'b1;
        dmem_we     = (opcode == OP_SW);
        alu_src_imm = 1'b1;
        if (dmem_ack) begin
          if (opcode == OP_SW) begin
            state_nx = FETCH;
            retire   = 1'b1;
          end else begin
            state_nx = WB;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx = ERROR;
        end
      end

      WB: begin
        busy       = 1'b1;
        reg_we     = 1'b1;
        reg_dst    = (itype == TYPE_R);
        mem_to_reg = (opcode == OP_LW);
        state_nx   = FETCH;
        retire     = 1'b1;
      end

      HALTED: begin
        halted = 1'b1;
        if (start) state_nx = FETCH;
      end

      ERROR: begin
        err = 1'b1;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl. Inputs change 1 time unit after each
// rising edge and outputs are sampled 1 unit later, well away from the edge.
// The counter is built 3 bits wide so saturation is reached in a short run.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int CNT_W   = 3;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [5:0]       opcode = 6'd0;
  logic             alu_zero = 1'b0;
  logic             imem_ack = 1'b0;
  logic             dmem_ack = 1'b0;
  logic             imem_req, dmem_req, dmem_we, ir_we, pc_we;
  logic [1:0]       pc_src;
  logic             reg_we, reg_dst, mem_to_reg, alu_src_imm;
  logic [1:0]       itype;
  logic             busy, halted, err;
  logic [CNT_W-1:0] instr_count;

  int nvec = 0;
  int nmis = 0;

  multicycle_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .alu_zero(alu_zero), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_imm(alu_src_imm),
    .itype(itype), .busy(busy), .halted(halted), .err(err),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Strobe bundle, MSB first:
  // imem_req dmem_req dmem_we ir_we pc_we pc_src[1:0] reg_we reg_dst mem_to_reg alu_src_imm
  logic [10:0] strb;
  assign strb = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src,
                 reg_we, reg_dst, mem_to_reg, alu_src_imm};

  // Status bundle: busy halted err
  logic [2:0] stat;
  assign stat = {busy, halted, err};

  function automatic logic [10:0] st(input logic im, input logic dm, input logic we,
                                     input logic ir, input logic pw, input logic [1:0] ps,
                                     input logic rw, input logic rd, input logic m2r,
                                     input logic imm);
    return {im, dm, we, ir, pw, ps, rw, rd, m2r, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One FETCH cycle with an immediate ack; the IR would present opcode
  // from here on.
  task automatic do_fetch(input logic [5:0] op, input string tag);
    opcode   = op;
    imem_ack = 1'b1;
    #1;
    chk(tag, 32'(strb), 32'(st(1,0,0,1,1,2'b00,0,0,0,0)));
    step();
    imem_ack = 1'b0;
  endtask

  initial begin
    int reqs;

    // Reset state
    #1;
    chk("rst_strobes", 32'(strb), 32'd0);
    chk("rst_status",  32'(stat), 32'd0);
    chk("rst_itype",   32'(itype), 32'd0);
    chk("rst_count",   32'(instr_count), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("idle_no_start", 32'(stat), 32'd0);

    // R type: FETCH, DECODE, EXEC, WB
    start = 1'b1;
    step();
    start = 1'b0;
    do_fetch(6'h00, "r_fetch");
    start = 1'b1;                       // ignored while busy
    #1;
    chk("r_decode", 32'({strb, stat}), 32'({st(0,0,0,0,0,2'b00,0,0,0,0), 3'b100}));
    step();
    start = 1'b0;
    chk("r_exec_itype", 32'(itype), 32'd0);
    chk("r_exec", 32'(strb), 32'(st(0,0,0,0,0,2'b00,0,0,0,0)));
    step();
    chk("r_wb", 32'(strb), 32'(st(0,0,0,0,0,2'b00,1,1,0,0)));
    step();
    chk("r_count", 32'(instr_count), 32'd1);

    // LW with dmem_ack on the fourth MEM cycle
    do_fetch(6'h23, "lw_fetch");
    step();
    chk("lw_exec", 32'({itype, strb}), 32'({2'b01, st(0,0,0,0,0,2'b00,0,0,0,1)}));
    step();
    reqs = 0;
    for (int i = 0; i < 4; i++) begin
      dmem_ack = (i == 3);
      #1;
      if (dmem_req && !dmem_we && alu_src_imm) reqs++;
      step();
    end
    dmem_ack = 1'b0;
    chk("lw_mem_cycles", 32'(reqs), 32'd4);
    chk("lw_wb", 32'(strb), 32'(st(0,0,0,0,0,2'b00,1,0,1,0)));
    step();
    chk("lw_count", 32'(instr_count), 32'd2);

    // J, BEQ not taken, BEQ taken
    do_fetch(6'h02, "j_fetch");
    step();
    chk("j_exec", 32'({itype, strb}), 32'({2'b10, st(0,0,0,0,1,2'b10,0,0,0,0)}));
    step();
    do_fetch(6'h04, "beq0_fetch");
    step();
    alu_zero = 1'b0;
    #1;
    chk("beq0_exec", 32'(strb), 32'(st(0,0,0,0,0,2'b01,0,0,0,1)));
    step();
    do_fetch(6'h04, "beq1_fetch");
    step();
    alu_zero = 1'b1;
    #1;
    chk("beq1_exec", 32'(strb), 32'(st(0,0,0,0,1,2'b01,0,0,0,1)));
    step();
    alu_zero = 1'b0;
    chk("branch_count", 32'(instr_count), 32'd5);

    // SW with immediate ack
    do_fetch(6'h2B, "sw_fetch");
    step(); step();
    dmem_ack = 1'b1;
    #1;
    chk("sw_mem", 32'(strb), 32'(st(0,1,1,0,0,2'b00,0,0,0,1)));
    step();
    dmem_ack = 1'b0;
    chk("sw_count", 32'(instr_count), 32'd6);

    // HALT, hold, resume
    do_fetch(6'h3F, "halt_fetch");
    step(); step();
    chk("halted", 32'({stat, instr_count}), 32'({3'b010, 3'd7}));
    step();
    chk("halt_hold", 32'({stat, strb}), 32'({3'b010, 11'd0}));
    start = 1'b1;
    step();
    start = 1'b0;
    chk("resume_fetch", 32'({imem_req, busy}), 32'b11);

    // J at full count: counter must stick at its maximum
    do_fetch(6'h02, "sat_fetch");
    step(); step();
    chk("sat_count", 32'(instr_count), 32'd7);

    // Fetch timeout: no ack for TIMEOUT cycles
    reqs = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (imem_req && !err) reqs++;
      step();
    end
    chk("to_req_cycles", 32'(reqs), 32'(TIMEOUT));
    chk("to_err", 32'({stat, strb}), 32'({3'b001, 11'd0}));
    start = 1'b1;
    step();
    start = 1'b0;
    chk("to_start_ignored", 32'({stat, imem_req}), 32'({3'b001, 1'b0}));
    rst_n = 1'b0;
    #1;
    chk("to_reset_clears", 32'({stat, instr_count}), 32'd0);
    step();
    rst_n = 1'b1;

    // Ack on the last wait cycle wins
    start = 1'b1;
    step();
    start = 1'b0;
    opcode = 6'h02;
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("late_ack_no_err", 32'(stat), 32'b100);
    step(); step();
    chk("late_ack_count", 32'(instr_count), 32'd1);

    // Reset while SW is in MEM
    do_fetch(6'h2B, "rst_sw_fetch");
    step(); step();
    chk("rst_sw_mem", 32'({dmem_req, dmem_we}), 32'b11);
    rst_n = 1'b0;
    #1;
    chk("rst_sw_drop", 32'({strb, stat, instr_count}), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("rst_sw_idle", 32'({stat, imem_req}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
